// File: rtl/fetch_pkg.sv
// Shared constants, entry layout and pointer helpers for the instruction fetch front end.
package fetch_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_PC_STEP  = 4;

  // Widest pc/instruction an entry can hold; narrower configurations zero-extend into it.
  localparam int ENTRY_PC_W   = 32;
  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]   pc;
    logic [ENTRY_DATA_W-1:0] data;
  } fetch_entry_t;

  // Index bits plus one wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory-side, decode-side and redirect signals of the fetch unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32
);
  // Handshakes: a transfer happens on a rising edge where the sender's valid
  // (imem_req / instr_valid) and the receiver's ready (imem_ready / instr_ready)
  // are both high. Valid may depend on state only (plus redirect_valid for
  // imem_req); ready may be driven freely. imem_rvalid has no backpressure.
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Circular prefetch buffer: slots are allocated at request time (pc), filled at
// response time (data) and drained from head; flush empties it at the alloc point.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int INSTR_W = DEF_INSTR_W,
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int PW      = ptr_width(DEPTH),
  localparam int IW      = PW - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               alloc_en,
  input  logic [ADDR_W-1:0]  alloc_pc,
  input  logic               fill_en,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic               deq_en,
  output logic [PW-1:0]      count,
  output logic               head_valid,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_data
);

  fetch_entry_t entries [DEPTH];

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] alloc_ptr;
  logic [IW-1:0] head_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] alloc_idx;

  assign head_idx  = head_ptr[IW-1:0];
  assign fill_idx  = fill_ptr[IW-1:0];
  assign alloc_idx = alloc_ptr[IW-1:0];

  // alloc and fill never target the same slot in one cycle: fill trails alloc
  // by 1..DEPTH-1 whenever both are enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr  <= '0;
      fill_ptr  <= '0;
      alloc_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= alloc_ptr;
      fill_ptr <= alloc_ptr;
    end else begin
      if (alloc_en) alloc_ptr <= alloc_ptr + PW'(1);
      if (fill_en)  fill_ptr  <= fill_ptr + PW'(1);
      if (deq_en)   head_ptr  <= head_ptr + PW'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_en && (alloc_idx == IW'(i))) entries[i].pc   <= ENTRY_PC_W'(alloc_pc);
        if (fill_en  && (fill_idx  == IW'(i))) entries[i].data <= ENTRY_DATA_W'(fill_data);
      end
    end
  end

  assign count      = alloc_ptr - head_ptr;
  assign head_valid = (fill_ptr != head_ptr);
  assign head_pc    = entries[head_idx].pc[ADDR_W-1:0];
  assign head_data  = entries[head_idx].data[INSTR_W-1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order requests under a
// DEPTH credit limit, drops responses of a redirected stream, feeds decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int RESET_PC = DEF_RESET_PC,
  parameter int PC_STEP  = DEF_PC_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int SW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     out_cnt;
  logic [PW-1:0]     drop_cnt;
  logic [PW-1:0]     alloc_count;
  logic [SW-1:0]     credit_used;
  logic              accept;
  logic              rsp_counted;
  logic              rsp_fill;
  logic              deq;
  logic              head_valid;

  // Slots held by the buffer plus responses still to be thrown away bound the
  // number of requests the memory can have in flight.
  assign credit_used  = SW'(alloc_count) + SW'(drop_cnt);
  assign bus.imem_req = rst_n && !bus.redirect_valid && (credit_used < SW'(DEPTH));
  assign bus.imem_addr = fetch_pc;

  assign accept      = bus.imem_req && bus.imem_ready;
  assign rsp_counted = bus.imem_rvalid && (out_cnt != '0);
  assign rsp_fill    = rsp_counted && !bus.redirect_valid && (drop_cnt == '0);
  assign deq         = head_valid && bus.instr_ready && !bus.redirect_valid;

  assign bus.instr_valid = head_valid;

  // On redirect every request still outstanding (already-doomed ones included)
  // belongs to a dead stream, so the drop count becomes exactly out_cnt minus
  // the response consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= ADDR_W'(RESET_PC);
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      out_cnt  <= out_cnt - PW'(rsp_counted);
      drop_cnt <= out_cnt - PW'(rsp_counted);
    end else begin
      if (accept) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      out_cnt <= out_cnt + PW'(accept) - PW'(rsp_counted);
      if (rsp_counted && (drop_cnt != '0)) drop_cnt <= drop_cnt - PW'(1);
    end
  end

  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (bus.redirect_valid),
    .alloc_en   (accept),
    .alloc_pc   (fetch_pc),
    .fill_en    (rsp_fill),
    .fill_data  (bus.imem_rdata),
    .deq_en     (deq),
    .count      (alloc_count),
    .head_valid (head_valid),
    .head_pc    (bus.instr_pc),
    .head_data  (bus.instr_data)
  );

  // A response with nothing outstanding is a memory protocol violation.
  rvalid_has_request: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.imem_rvalid && (out_cnt == '0))
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based stream model.
module tb_instr_fetch_unit;

  localparam int ADDR_W   = 10;
  localparam int INSTR_W  = 32;
  localparam int DEPTH    = 4;
  localparam int RESET_PC = 0;
  localparam int PC_STEP  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
    .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat_min, lat_max;
  logic [INSTR_W-1:0] data_key;

  logic [ADDR_W-1:0]         m_pc;        // next address the model expects to fetch
  logic [ADDR_W-1:0]         live_q[$];   // accepted, current stream, no data yet
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];    // {pc,data} arrived, awaiting decode
  logic [ADDR_W-1:0]         maddr_q[$];  // memory pipeline: request addresses
  int                        due_q[$];    // memory pipeline: cycle the response returns
  bit                        stale_q[$];  // memory pipeline: response belongs to a dead stream

  // observations from the latest cycle
  logic              s_req, s_valid;
  logic [ADDR_W-1:0] s_addr, s_pc;
  logic [INSTR_W-1:0] s_data;
  int                acc_seen;
  logic [ADDR_W-1:0] acc_q[$];

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return INSTR_W'(a) ^ data_key;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit rst, input bit rdy, input bit irdy, input bit redir,
                      input logic [ADDR_W-1:0] rpc);
    bit rv, exp_req, exp_valid, stale;
    int n_stale;
    logic [ADDR_W+INSTR_W-1:0] head;
    logic [ADDR_W-1:0] raddr, lpc;
    rv = 1'b0; stale = 1'b0; raddr = '0;
    @(negedge clk);
    rst_n              = rst;
    bus.imem_ready     = rdy;
    bus.instr_ready    = irdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (rst && (maddr_q.size() > 0)) rv = (due_q[0] <= cyc);
    bus.imem_rvalid = rv;
    if (rv) bus.imem_rdata = mem_word(maddr_q[0]);
    else    bus.imem_rdata = INSTR_W'($urandom);
    #1;
    s_req = bus.imem_req; s_valid = bus.instr_valid; s_addr = bus.imem_addr;
    s_pc = bus.instr_pc; s_data = bus.instr_data;

    n_stale = 0;
    foreach (stale_q[i]) if (stale_q[i]) n_stale++;
    exp_req   = rst && !redir && ((live_q.size() + exp_q.size() + n_stale) < DEPTH);
    exp_valid = (exp_q.size() > 0);
    chk("imem_req", 32'(s_req), 32'(exp_req));
    chk("imem_addr", 32'(s_addr), 32'(m_pc));
    chk("instr_valid", 32'(s_valid), 32'(exp_valid));
    if (exp_valid) begin
      head = exp_q[0];
      chk("instr_pc", 32'(s_pc), 32'(head[ADDR_W+INSTR_W-1:INSTR_W]));
      chk("instr_data", 32'(s_data), 32'(head[INSTR_W-1:0]));
    end
    if ((s_req === 1'b1) && rdy) begin
      acc_seen++;
      acc_q.push_back(s_addr);
    end

    // model reaction to the coming rising edge
    if (!rst) begin
      live_q.delete(); exp_q.delete(); maddr_q.delete(); due_q.delete(); stale_q.delete();
      m_pc = ADDR_W'(RESET_PC);
    end else begin
      if (rv) begin
        raddr = maddr_q.pop_front();
        void'(due_q.pop_front());
        stale = stale_q.pop_front();
      end
      if (redir) begin
        foreach (stale_q[i]) stale_q[i] = 1'b1;
        live_q.delete();
        exp_q.delete();
        m_pc = rpc;
      end else begin
        if (exp_valid && irdy) void'(exp_q.pop_front());
        if (rv && !stale) begin
          lpc = live_q.pop_front();
          exp_q.push_back({lpc, mem_word(raddr)});
        end
        if (exp_req && rdy) begin
          maddr_q.push_back(m_pc);
          due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
          stale_q.push_back(1'b0);
          live_q.push_back(m_pc);
          m_pc = m_pc + ADDR_W'(PC_STEP);
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic expect_first_pc(input string tag, input logic [ADDR_W-1:0] pc, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, '0);
      if (!seen && s_valid === 1'b1) begin
        seen = 1'b1;
        chk(tag, 32'(s_pc), 32'(pc));
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [ADDR_W-1:0] wrap_exp [3];
  bit r_rst, r_rdy, r_irdy, r_redir;

  initial begin
    rst_n = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
    lat_min = 1; lat_max = 1; data_key = '0;
    m_pc = ADDR_W'(RESET_PC);

    // reset state, then streaming with a 1-cycle memory returning data = address
    do_reset();
    chk("reset_instr_pc", 32'(s_pc), 32'd0);
    chk("reset_instr_data", 32'(s_data), 32'd0);
    chk("reset_imem_addr", 32'(s_addr), 32'(RESET_PC));
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // decode stalled: only DEPTH requests may be accepted
    do_reset();
    acc_seen = 0; acc_q.delete();
    repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("stall_accepts", 32'(acc_seen), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      if (i < acc_q.size()) chk("stall_addr", 32'(acc_q[i]), 32'(i * PC_STEP));
    acc_q.delete();
    repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("resume_seen", 32'(acc_q.size() > 0), 32'd1);
    if (acc_q.size() > 0) chk("resume_addr", 32'(acc_q[0]), 32'(DEPTH * PC_STEP));

    // redirect with two requests outstanding, latency 3
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, ADDR_W'(10'h100));
    expect_first_pc("redirect_first_pc", ADDR_W'(10'h100), 12);

    // redirect coinciding with a response and a dequeue
    lat_min = 1; lat_max = 1; data_key = 32'hC0DE_0000;
    do_reset();
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, ADDR_W'(10'h200));
    expect_first_pc("same_cycle_first_pc", ADDR_W'(10'h200), 8);

    // address wrap
    wrap_exp[0] = 10'h3FC; wrap_exp[1] = 10'h000; wrap_exp[2] = 10'h004;
    step(1'b1, 1'b1, 1'b1, 1'b1, ADDR_W'(10'h3FC));
    acc_q.delete();
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("wrap_count", 32'(acc_q.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < acc_q.size()) chk("wrap_addr", 32'(acc_q[i]), 32'(wrap_exp[i]));

    // reset while the buffer is full
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("rst_req_low", 32'(s_req), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    chk("rst_valid_low", 32'(s_valid), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'(RESET_PC));
    chk("rst_req_held", 32'(s_req), 32'd0);

    // randomized traffic
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 4000; i++) begin
      r_rst   = ($urandom_range(0, 599) != 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_irdy  = ($urandom_range(0, 9) < 7);
      r_redir = r_rst && ($urandom_range(0, 24) == 0);
      step(r_rst, r_rdy, r_irdy, r_redir, ADDR_W'($urandom_range(0, 255) * 4));
    end
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
